// File: rtl/lm70_ctrl_pkg.sv
// Shared types and constants for the LM70 temperature-sensor read controller.
package lm70_ctrl_pkg;

  localparam int LM70_NBITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/lm70_ctrl_tick.sv
// Half-period timer for the LM70 serial clock: cleared on phase entry,
// last_o marks the final CLK_DIV cycle of the current phase.
module lm70_ctrl_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  output logic last_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == 8'(CLK_DIV - 1));

endmodule

// File: rtl/lm70_ctrl.sv
// LM70 read controller: one START clocks a full frame from the sensor into temp_o.
// Optional over-temperature flag (temp_hi_i / alarm_o) built only with LM70_CTRL_ALARM_EN.
//
// state     | meaning
// ST_IDLE   | CS high, waiting for START
// ST_SETUP  | CS low, first bit settling at the sensor
// ST_SCK_HI | SCK high, sample SIO on last cycle
// ST_SCK_LO | SCK low, sensor shifts next bit
// ST_FINISH | CS high, TEMP just loaded, DONE pulse
module lm70_ctrl
  import lm70_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = LM70_NBITS
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             sio_i,
`ifdef LM70_CTRL_ALARM_EN
  input  logic [NBITS-1:0] temp_hi_i,
  output logic             alarm_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [NBITS-1:0] temp_o,
  output logic             cs_o,
  output logic             sck_o
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] temp_q, temp_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             last;
  logic             tick_clr;
`ifdef LM70_CTRL_ALARM_EN
  logic             alarm_q, alarm_d;
`endif

  // Counter restarts on every phase change and stays parked while idle.
  assign tick_clr = (state_d != state_q) || (state_q == ST_IDLE);

  lm70_ctrl_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (tick_clr),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    temp_d  = temp_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    sck_d   = sck_q;
`ifdef LM70_CTRL_ALARM_EN
    alarm_d = alarm_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
          bit_d   = CW'(NBITS - 1);
        end
      end
      ST_SETUP: begin
        if (last) begin
          state_d = ST_SCK_HI;
          sck_d   = 1'b1;
        end
      end
      ST_SCK_HI: begin
        if (last) begin
          shift_d = {shift_q[NBITS-2:0], sio_i};
          state_d = ST_SCK_LO;
          sck_d   = 1'b0;
        end
      end
      ST_SCK_LO: begin
        if (last) begin
          if (bit_q == '0) begin
            state_d = ST_FINISH;
            cs_d    = 1'b1;
            temp_d  = shift_q;
            done_d  = 1'b1;
`ifdef LM70_CTRL_ALARM_EN
            alarm_d = ($signed(shift_q) >= $signed(temp_hi_i));
`endif
          end else begin
            bit_d   = bit_q - CW'(1);
            state_d = ST_SCK_HI;
            sck_d   = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      temp_q  <= '0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
`ifdef LM70_CTRL_ALARM_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      temp_q  <= temp_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
`ifdef LM70_CTRL_ALARM_EN
      alarm_q <= alarm_d;
`endif
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign temp_o = temp_q;
  assign cs_o   = cs_q;
  assign sck_o  = sck_q;
`ifdef LM70_CTRL_ALARM_EN
  assign alarm_o = alarm_q;
`endif

endmodule

// File: doc/lm70_ctrl.md
LM70_CTRL -- requirements
Module: lm70_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, CLK cycles per SCK half-period (legal range 1..255).
REQ-002 Parameter NBITS, default 16, bits per LM70 read frame.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RSTN  input  1  reset, synchronous, active-low.
REQ-005 START  input  1  one-cycle read request, honoured only in IDLE.
REQ-006 BUSY  output  1  high whenever state is not IDLE.
REQ-007 DONE  output  1  one-cycle pulse when TEMP holds a new frame.
REQ-008 TEMP  output  NBITS  last completed frame, MSB first as received.
REQ-009 CS  output  1  sensor chip select, active-low.
REQ-010 SCK  output  1  serial clock to the sensor, idle low.
REQ-011 SIO  input  1  serial data from the sensor.

Function
REQ-012 The block SHALL be a five-state FSM: IDLE, SETUP, SCK_HI, SCK_LO, FINISH.
REQ-013 IDLE: CS=1, SCK=0; START=1 -> SETUP at the next edge, with CS=0 registered at that same edge.
REQ-014 SETUP SHALL last CLK_DIV cycles with SCK=0, then go to SCK_HI; bit counter = NBITS-1.
REQ-015 SCK_HI SHALL last CLK_DIV cycles with SCK=1, and SIO SHALL be shifted into the LSB of an internal shift register on the last cycle of the phase.
REQ-016 SCK_LO SHALL last CLK_DIV cycles with SCK=0; on exit, bit counter 0 -> FINISH, otherwise decrement and go to SCK_HI.
REQ-017 The FINISH entry edge SHALL set CS=1, load TEMP from the shift register, and assert DONE for exactly one cycle; FINISH -> IDLE unconditionally.
REQ-018 CS low duration SHALL be exactly CLK_DIV*(1+2*NBITS) cycles (132 for defaults); SCK SHALL produce exactly NBITS rising edges per frame.
REQ-019 The first bit sampled SHALL be TEMP[NBITS-1]; the sensor's first bit is valid from CS falling, and later bits change after each SCK falling edge.
REQ-020 START while BUSY=1, including during FINISH, SHALL be ignored and SHALL NOT be queued.
REQ-021 Back-to-back reads SHALL leave CS high for at least 2 cycles (FINISH + IDLE).
REQ-022 TEMP SHALL change only on the DONE edge and hold its value otherwise.
REQ-023 Registered outputs only: CS, SCK, DONE, and TEMP SHALL come straight from flops, with no combinational path from SIO or START.

Reset
REQ-024 RSTN=0 at a CLK edge SHALL force IDLE, CS=1, SCK=0, DONE=0, TEMP=0, counters=0, and clear the alarm state.
REQ-025 Reset mid-frame SHALL abort the frame with no DONE pulse; the next START SHALL begin a full new frame.

Configuration
REQ-026 Macro LM70_CTRL_ALARM_EN: when defined, the block SHALL add input TEMP_HI[NBITS-1:0] and a registered output ALARM.
REQ-027 ALARM SHALL be updated on each DONE edge to (signed new TEMP >= signed TEMP_HI), and held between frames.
REQ-028 Without the macro, TEMP_HI, ALARM, and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package lm70_ctrl_pkg SHALL hold the FSM state typedef and the constant LM70_NBITS=16.
REQ-030 Sub-module lm70_ctrl_tick SHALL be the half-period counter: it is cleared on each phase entry and emits a last-cycle strobe at count CLK_DIV-1.
REQ-031 The FSM, shift register, and alarm compare SHALL reside in lm70_ctrl.

Verification
REQ-032 The bench SHALL connect the LM70 sensor model with CS, SCK, and SIO, its RSTN tied to the bench reset, and TEMP_SET driven.
REQ-033 TEMP_SET=16'h0C9F (+25 C), defaults, one START -> CS low for 132 cycles, 16 SCK rising edges, DONE once, TEMP=16'h0C9F.
REQ-034 TEMP_SET=16'hF39F (-25 C), CLK_DIV=1 -> CS low for 33 cycles, TEMP=16'hF39F; with LM70_CTRL_ALARM_EN and TEMP_HI=16'h0000, ALARM=0.
REQ-035 START held high continuously -> successive frames with CS high exactly 2 cycles between them, and one DONE per frame.
REQ-036 RSTN=0 during the 8th SCK_HI phase -> next edge CS=1, SCK=0, TEMP=0, no DONE; a fresh START then returns the correct value.
REQ-037 LM70_CTRL_ALARM_EN, TEMP_HI=16'h0C9F, TEMP_SET 16'h0C7F then 16'h0C9F -> ALARM 0 after frame 1, 1 after frame 2.
